// File: rtl/clock_divider_multi.sv
// clock_divider_multi
//   Multi-channel, runtime-programmable clock divider. Every channel has its own
//   counter, divisor and high-phase length, so period and duty cycle are set
//   independently per channel. New settings are posted through a valid/ready
//   port and only take effect at that channel's period boundary (or at once
//   while the channel is disabled), so a running output never glitches.
//
//   Optional feature: define CLKDIV_TICK_EN to add the per-channel tick output
//   (one-cycle pulse per period, usable as a clock enable on clock_in).
//
// Ports
//   clock_in   in   board clock, all logic on rising edge
//   reset      in   asynchronous, active-high reset
//   enable     in   [CHANNELS] per-channel run enable
//   cfg_valid  in   config request
//   cfg_ready  out  config accepted on cfg_valid && cfg_ready at a rising edge
//   cfg_chan   in   [CH_W] target channel (out-of-range: accepted, discarded)
//   cfg_div    in   [CNT_W] new period in clock_in cycles (clamped to >= 2)
//   cfg_high   in   [CNT_W] new high-phase length (clamped to <= period)
//   clock_out  out  [CHANNELS] divided outputs, registered
//   tick       out  [CHANNELS] wrap pulse, registered (CLKDIV_TICK_EN only)

module clock_divider_multi #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 10,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_high,
  output logic [CHANNELS-1:0] clock_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic [CHANNELS-1:0] tick
`endif
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_DIV / 2);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CHANNELS-1:0] pend;
  logic [CNT_W-1:0]    san_div;
  logic [CNT_W-1:0]    san_high;

  // A period below 2 cannot produce both phases; a high phase longer than the
  // period is the same waveform as high == period (constant high).
  always_comb begin
    san_div  = (cfg_div < TWO) ? TWO : cfg_div;
    san_high = (cfg_high > san_div) ? san_div : cfg_high;
  end

  // Ready depends only on the addressed channel's pending flag; channels that
  // do not exist never match, so such requests see ready high and vanish.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CH_W'(i)) cfg_ready = ~pend[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_high;
    logic             pend_q;
    logic             clk_q;
    logic             wrap;
    logic             accept;

    assign wrap   = (cnt == div - ONE);
    assign accept = cfg_valid && cfg_ready && (cfg_chan == CH_W'(g));

    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        cnt       <= '0;
        div       <= DIV_RST;
        high      <= HIGH_RST;
        pend_div  <= DIV_RST;
        pend_high <= HIGH_RST;
        pend_q    <= 1'b0;
        clk_q     <= 1'b0;
      end else begin
        if (!enable[g]) begin
          // Idle channel: hold at phase 0 and take any pending setting now.
          cnt   <= '0;
          clk_q <= 1'b0;
          if (pend_q) begin
            div    <= pend_div;
            high   <= pend_high;
            pend_q <= 1'b0;
          end
        end else begin
          clk_q <= (cnt < high);
          if (wrap) begin
            cnt <= '0;
            if (pend_q) begin
              div    <= pend_div;
              high   <= pend_high;
              pend_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        // Accept only happens while pend_q is clear, so it never collides
        // with an apply on this channel; a same-edge wrap uses the old values.
        if (accept) begin
          pend_q    <= 1'b1;
          pend_div  <= san_div;
          pend_high <= san_high;
        end
      end
    end

    assign clock_out[g] = clk_q;
    assign pend[g]      = pend_q;

`ifdef CLKDIV_TICK_EN
    logic tick_q;

    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        tick_q <= 1'b0;
      end else begin
        tick_q <= enable[g] && wrap;
      end
    end

    assign tick[g] = tick_q;
`endif
  end

endmodule
